instr_encoder: RTL and testbench

- Instruction encoder: the inverse of the immediate-extension stage. It packs opcode, funct3, register indices and a 32-bit immediate into an RV32I instruction word.
- Also expands the LI pseudo-instruction into a LUI+ADDI pair or a single instruction.
- Feeds generated instructions (boot stubs, self-test, trap trampolines) into instruction memory or the fetch path.
- valid/ready on both sides, with a registered output.

---
 rtl/instr_enc_pkg.sv | 31 +++
 rtl/instr_encoder_if.sv | 35 +++
 rtl/instr_field_pack.sv | 28 ++
 rtl/instr_encoder.sv | 169 ++++++++++++++++
 tb/tb_instr_encoder.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_enc_pkg.sv
// Shared constants, state encoding and helpers for the RV32I instruction encoder.
// INSTR_ENC_RANGE_CHECK_EN (see instr_encoder.sv) enables immediate range flagging.
package instr_enc_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] KIND_I  = 3'b000;
  localparam logic [2:0] KIND_S  = 3'b001;
  localparam logic [2:0] KIND_B  = 3'b010;
  localparam logic [2:0] KIND_J  = 3'b011;
  localparam logic [2:0] KIND_U  = 3'b100;
  localparam logic [2:0] KIND_LI = 3'b101;

  localparam logic [6:0]  OP_LUI = 7'b0110111;
  localparam logic [6:0]  OP_IMM = 7'b0010011;
  localparam logic [31:0] NOP    = 32'h00000013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ONE  = 2'd1,
    ST_HI   = 2'd2
  } state_t;

  // True when v is representable as a signed value whose sign bit sits at index msb.
  function automatic logic fits_signed(input logic [31:0] v, input int msb);
    logic [31:0] hi_mask;
    hi_mask = 32'hFFFF_FFFF << msb;
    return ((v & hi_mask) == hi_mask) || ((v & hi_mask) == 32'h0);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and output streams of the instruction encoder.
// Both sides: a word moves on a cycle where valid and ready are both high; valid never waits on ready.
interface instr_encoder_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_kind;
  logic [6:0]      req_opcode;
  logic [2:0]      req_funct3;
  logic [4:0]      req_rd;
  logic [4:0]      req_rs1;
  logic [4:0]      req_rs2;
  logic [XLEN-1:0] req_imm;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] instr_out;
  logic            out_last;
  logic            out_err;

  modport slave (
    input  req_valid, req_kind, req_opcode, req_funct3, req_rd, req_rs1, req_rs2, req_imm,
    output req_ready,
    output out_valid, instr_out, out_last, out_err,
    input  out_ready
  );

  modport master (
    output req_valid, req_kind, req_opcode, req_funct3, req_rd, req_rs1, req_rs2, req_imm,
    input  req_ready,
    input  out_valid, instr_out, out_last, out_err,
    output out_ready
  );
endinterface

// File: rtl/instr_field_pack.sv
// Purely combinational RV32I field packer: scatters immediate bits per format.
// Kinds other than I/S/B/J/U produce a NOP.
module instr_field_pack
  import instr_enc_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = NOP;
    case (kind)
      KIND_I: word = {imm[11:0], rs1, funct3, rd, opcode};
      KIND_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      KIND_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      KIND_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      KIND_U: word = {imm[31:12], rd, opcode};
      default: word = NOP;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Registered RV32I instruction encoder with LI expansion into LUI+ADDI.
// Optional macro INSTR_ENC_RANGE_CHECK_EN flags out-of-range immediates and illegal kinds on out_err.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int XLEN = 32
)(
  input  logic              clk,
  input  logic              reset,
  instr_encoder_if.slave    bus,
  output state_t            dbg_state
);

  state_t          state;
  logic            out_valid_q;
  logic [XLEN-1:0] instr_q;
  logic            last_q;
  logic            err_q;
  logic [4:0]      pend_rd;
  logic [11:0]     pend_lo;

  logic consume;
  logic req_ready;
  logic accept;

  assign consume   = out_valid_q & bus.out_ready;
  assign req_ready = (state == ST_IDLE) | (consume & last_q);
  assign accept    = bus.req_valid & req_ready;

  // LI split: the ADDI sign-extends lo, so hi absorbs lo's sign bit.
  logic            is_li;
  logic [11:0]     li_lo;
  logic [19:0]     li_hi;
  logic            li_fits;
  logic            li_two;

  assign is_li   = (bus.req_kind == KIND_LI);
  assign li_lo   = bus.req_imm[11:0];
  assign li_hi   = bus.req_imm[31:12] + {19'b0, bus.req_imm[11]};
  assign li_fits = fits_signed(bus.req_imm, 11);
  assign li_two  = !li_fits && (li_lo != 12'h000);

  logic [2:0]      pk_kind;
  logic [6:0]      pk_op;
  logic [2:0]      pk_f3;
  logic [4:0]      pk_rd;
  logic [4:0]      pk_rs1;
  logic [4:0]      pk_rs2;
  logic [XLEN-1:0] pk_imm;
  logic [XLEN-1:0] pk_word;

  // In HI no request can be accepted, so the packer is free to build the pending ADDI.
  always_comb begin
    pk_kind = bus.req_kind;
    pk_op   = bus.req_opcode;
    pk_f3   = bus.req_funct3;
    pk_rd   = bus.req_rd;
    pk_rs1  = bus.req_rs1;
    pk_rs2  = bus.req_rs2;
    pk_imm  = bus.req_imm;
    if (state == ST_HI) begin
      pk_kind = KIND_I;
      pk_op   = OP_IMM;
      pk_f3   = 3'b000;
      pk_rd   = pend_rd;
      pk_rs1  = pend_rd;
      pk_rs2  = 5'd0;
      pk_imm  = {{20{pend_lo[11]}}, pend_lo};
    end else if (is_li) begin
      pk_f3  = 3'b000;
      pk_rs1 = 5'd0;
      pk_rs2 = 5'd0;
      if (li_fits) begin
        pk_kind = KIND_I;
        pk_op   = OP_IMM;
        pk_imm  = bus.req_imm;
      end else begin
        pk_kind = KIND_U;
        pk_op   = OP_LUI;
        pk_imm  = {li_hi, 12'h000};
      end
    end
  end

  instr_field_pack u_pack (
    .kind   (pk_kind),
    .opcode (pk_op),
    .funct3 (pk_f3),
    .rd     (pk_rd),
    .rs1    (pk_rs1),
    .rs2    (pk_rs2),
    .imm    (pk_imm),
    .word   (pk_word)
  );

  logic req_err;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic is_shift;
  assign is_shift = (bus.req_kind == KIND_I) && bus.req_opcode[4] &&
                    ((bus.req_funct3 == 3'b001) || (bus.req_funct3 == 3'b101));

  always_comb begin
    req_err = 1'b0;
    case (bus.req_kind)
      KIND_I: begin
        if (is_shift)
          req_err = (bus.req_imm[31:12] != 20'h0) ||
                    ((bus.req_imm[11:5] != 7'h00) && (bus.req_imm[11:5] != 7'h20));
        else
          req_err = !fits_signed(bus.req_imm, 11);
      end
      KIND_S:  req_err = !fits_signed(bus.req_imm, 11);
      KIND_B:  req_err = bus.req_imm[0] || !fits_signed(bus.req_imm, 12);
      KIND_J:  req_err = bus.req_imm[0] || !fits_signed(bus.req_imm, 20);
      KIND_U:  req_err = (bus.req_imm[11:0] != 12'h000);
      KIND_LI: req_err = 1'b0;
      default: req_err = 1'b1;
    endcase
  end
`else
  assign req_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      pend_rd     <= 5'd0;
      pend_lo     <= 12'h000;
    end else if (state == ST_HI) begin
      if (consume) begin
        instr_q <= pk_word;
        last_q  <= 1'b1;
        err_q   <= 1'b0;
        state   <= ST_ONE;
      end
    end else if (accept) begin
      out_valid_q <= 1'b1;
      instr_q     <= pk_word;
      err_q       <= req_err;
      if (is_li && li_two) begin
        last_q  <= 1'b0;
        pend_rd <= bus.req_rd;
        pend_lo <= li_lo;
        state   <= ST_HI;
      end else begin
        last_q <= 1'b1;
        state  <= ST_ONE;
      end
    end else if (consume) begin
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      state       <= ST_IDLE;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.instr_out = instr_q;
  assign bus.out_last  = last_q;
  assign bus.out_err   = err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: reset, LI expansion, formats, hold/reset, back-to-back.
module tb_instr_encoder;
  import instr_enc_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg_state;
  int     n_cmp;
  int     n_fail;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] kind, input logic [6:0] op, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
    bus.req_valid  = 1'b1;
    bus.req_kind   = kind;
    bus.req_opcode = op;
    bus.req_funct3 = f3;
    bus.req_rd     = rd;
    bus.req_rs1    = rs1;
    bus.req_rs2    = rs2;
    bus.req_imm    = imm;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.req_kind = 3'd0; bus.req_opcode = 7'd0; bus.req_funct3 = 3'd0;
    bus.req_rd = 5'd0; bus.req_rs1 = 5'd0; bus.req_rs2 = 5'd0; bus.req_imm = 32'd0;
    step(); step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.instr_out !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", bus.instr_out); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b want 0", bus.out_last); end
    n_cmp++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.out_err); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_li_pair();
    bus.out_ready = 1'b1;
    drive_req(KIND_LI, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL li_rdy0: got %b want 1", bus.req_ready); end
    step();
    bus.req_valid = 1'b0;
    #1;
    n_cmp++; if (bus.instr_out !== 32'h123452B7 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL li_lui: got %h v%b want 123452b7 v1", bus.instr_out, bus.out_valid); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL li_lui_last: got %b want 0", bus.out_last); end
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL li_lui_rdy: got %b want 0", bus.req_ready); end
    step();
    n_cmp++; if (bus.instr_out !== 32'h67828293 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL li_addi: got %h v%b want 67828293 v1", bus.instr_out, bus.out_valid); end
    n_cmp++; if (bus.out_last !== 1'b1) begin n_fail++; $display("FAIL li_addi_last: got %b want 1", bus.out_last); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL li_addi_rdy: got %b want 1", bus.req_ready); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL li_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_li_single_and_carry();
    bus.out_ready = 1'b1;
    drive_req(KIND_LI, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800);
    step();
    bus.req_valid = 1'b0;
    #1;
    n_cmp++; if (bus.instr_out !== 32'h80000093 || bus.out_last !== 1'b1) begin n_fail++; $display("FAIL li_neg: got %h l%b want 80000093 l1", bus.instr_out, bus.out_last); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL li_neg_drain: got %b want 0", bus.out_valid); end
    drive_req(KIND_LI, 7'h00, 3'd0, 5'd2, 5'd0, 5'd0, 32'h00000FFF);
    step();
    bus.req_valid = 1'b0;
    #1;
    n_cmp++; if (bus.instr_out !== 32'h00001137 || bus.out_last !== 1'b0) begin n_fail++; $display("FAIL li_carry_lui: got %h l%b want 00001137 l0", bus.instr_out, bus.out_last); end
    step();
    n_cmp++; if (bus.instr_out !== 32'hFFF10113 || bus.out_last !== 1'b1) begin n_fail++; $display("FAIL li_carry_addi: got %h l%b want fff10113 l1", bus.instr_out, bus.out_last); end
    step();
    // LI whose low half is zero collapses to one LUI.
    drive_req(KIND_LI, 7'h00, 3'd0, 5'd7, 5'd0, 5'd0, 32'hABCDE000);
    step();
    bus.req_valid = 1'b0;
    #1;
    n_cmp++; if (bus.instr_out !== 32'hABCDE3B7 || bus.out_last !== 1'b1) begin n_fail++; $display("FAIL li_lui_only: got %h l%b want abcde3b7 l1", bus.instr_out, bus.out_last); end
    step();
  endtask

  task automatic test_formats();
    logic exp_err;
    bus.out_ready = 1'b1;
    drive_req(KIND_B, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    step();
    bus.req_valid = 1'b0;
    #1;
    n_cmp++; if (bus.instr_out !== 32'hFE208EE3 || bus.out_err !== 1'b0) begin n_fail++; $display("FAIL b_ok: got %h e%b want fe208ee3 e0", bus.instr_out, bus.out_err); end
    step();
`ifdef INSTR_ENC_RANGE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    drive_req(KIND_B, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'h00000003);
    step();
    bus.req_valid = 1'b0;
    #1;
    n_cmp++; if (bus.instr_out !== 32'h00208163 || bus.out_err !== exp_err) begin n_fail++; $display("FAIL b_odd: got %h e%b want 00208163 e%b", bus.instr_out, bus.out_err, exp_err); end
    step();
    drive_req(KIND_I, 7'h13, 3'd5, 5'd3, 5'd3, 5'd0, 32'h00000407);
    step();
    bus.req_valid = 1'b0;
    #1;
    n_cmp++; if (bus.instr_out !== 32'h4071D193 || bus.out_err !== 1'b0) begin n_fail++; $display("FAIL srai: got %h e%b want 4071d193 e0", bus.instr_out, bus.out_err); end
    step();
    // SW x5, -4(x2)
    drive_req(KIND_S, 7'h23, 3'd2, 5'd0, 5'd2, 5'd5, 32'hFFFFFFFC);
    step();
    bus.req_valid = 1'b0;
    #1;
    n_cmp++; if (bus.instr_out !== 32'hFE512E23 || bus.out_err !== 1'b0) begin n_fail++; $display("FAIL sw: got %h e%b want fe512e23 e0", bus.instr_out, bus.out_err); end
    step();
    // JAL x1, +8
    drive_req(KIND_J, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00000008);
    step();
    bus.req_valid = 1'b0;
    #1;
    n_cmp++; if (bus.instr_out !== 32'h008000EF || bus.out_err !== 1'b0) begin n_fail++; $display("FAIL jal: got %h e%b want 008000ef e0", bus.instr_out, bus.out_err); end
    step();
    drive_req(3'b110, 7'h33, 3'd1, 5'd9, 5'd9, 5'd9, 32'h12345678);
    step();
    bus.req_valid = 1'b0;
    #1;
    n_cmp++; if (bus.instr_out !== 32'h00000013 || bus.out_err !== exp_err || bus.out_last !== 1'b1) begin n_fail++; $display("FAIL illegal: got %h e%b l%b want 00000013 e%b l1", bus.instr_out, bus.out_err, bus.out_last, exp_err); end
    step();
  endtask

  task automatic test_hold_and_reset();
    drive_req(KIND_LI, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    bus.out_ready = 1'b0;
    step();
    // Keep a competing request valid so a wrong req_ready would show as an accept.
    drive_req(KIND_U, 7'h37, 3'd0, 5'd4, 5'd0, 5'd0, 32'h11111000);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.instr_out !== 32'h123452B7 || bus.out_last !== 1'b0) begin n_fail++; $display("FAIL hold%0d: got v%b %h l%b want v1 123452b7 l0", i, bus.out_valid, bus.instr_out, bus.out_last); end
      n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL hold_rdy%0d: got %b want 0", i, bus.req_ready); end
      step();
    end
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hi_rst_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.req_ready !== 1'b1 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL hi_rst_idle: got r%b s%0d want r1 s0", bus.req_ready, dbg_state); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL no_addi%0d: got v%b %h want v0", i, bus.out_valid, bus.instr_out); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] imms [4];
    logic [4:0]  rds  [4];
    logic [6:0]  ops  [4];
    logic [31:0] exps [4];
    imms = '{32'h00001000, 32'hABCDE000, 32'hFFFFF000, 32'h80000000};
    rds  = '{5'd1, 5'd10, 5'd31, 5'd0};
    ops  = '{7'h37, 7'h17, 7'h37, 7'h17};
    exps = '{32'h000010B7, 32'hABCDE517, 32'hFFFFFFB7, 32'h80000017};
    bus.out_ready = 1'b1;
    drive_req(KIND_U, ops[0], 3'd0, rds[0], 5'd0, 5'd0, imms[0]);
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy0: got %b want 1", bus.req_ready); end
    step();
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.instr_out !== exps[i-1] || bus.out_last !== 1'b1) begin n_fail++; $display("FAIL b2b_word%0d: got v%b %h want v1 %h", i-1, bus.out_valid, bus.instr_out, exps[i-1]); end
      if (i < 4) drive_req(KIND_U, ops[i], 3'd0, rds[i], 5'd0, 5'd0, imms[i]);
      else bus.req_valid = 1'b0;
      #1;
      if (i < 4) begin
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy%0d: got %b want 1", i, bus.req_ready); end
      end
      step();
    end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", bus.out_valid); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_li_pair();
    test_li_single_and_carry();
    test_formats();
    test_hold_and_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
